// File: rtl/axi_sim_console_if.sv
// axi_sim_console_if
//   AXI subset carried between the CPU fabric (master) and the console /
//   simulation-control slave. Only the fields the slave uses are present.
//
//   Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on
//   the rising clock edge where both valid and ready are high. Once valid is
//   raised, the sender holds it and the payload stable until that transfer.
//   Valid never waits on ready.
//
//   Signals:
//     AW: awvalid/awready, awaddr[ADDR_W], awid[ID_W], awlen[4]
//     W : wvalid/wready, wdata[DATA_W], wstrb[DATA_W/8], wlast
//     B : bvalid/bready, bid[ID_W], bresp[2]
//     AR: arvalid/arready, araddr[ADDR_W], arid[ID_W], arlen[4]
//     R : rvalid/rready, rdata[DATA_W], rid[ID_W], rresp[2], rlast
interface axi_sim_console_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 128,
  parameter int ID_W   = 8
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [3:0]        awlen;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [3:0]        arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awid, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rdata, rid, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rdata, rid, rresp, rlast
  );
endinterface

// File: rtl/axi_sim_console_slave.sv
// axi_sim_console_slave
//   Terminates the console / simulation-control window. Single-beat stores to
//   TX_DATA (offset 0x00) push one character into a FIFO drained on the char
//   stream; stores to EXIT (0x10) pulse exit_valid and latch the first exit
//   code; STATUS (0x08) reads back FIFO state and exit_done. Bursts are
//   consumed without side effects and answered with SLVERR.
//
//   Ports:
//     clk, rst_b            clock, asynchronous active-low reset
//     bus (slave modport)   AXI AW/W/B/AR/R channels
//     char_valid/ready/data character stream (FIFO head)
//     exit_valid            one-cycle pulse per EXIT store
//     exit_done, exit_code  sticky flag and code of the first EXIT store
//     w_state_dbg           write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//     r_state_dbg           read FSM state (R_IDLE=0, R_DATA=1)
module axi_sim_console_slave #(
  parameter int              ADDR_W     = 40,
  parameter int              DATA_W     = 128,
  parameter int              ID_W       = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 40'h0090000000,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  axi_sim_console_if.slave bus,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        exit_valid,
  output logic        exit_done,
  output logic [31:0] exit_code,
  output logic [1:0]  w_state_dbg,
  output logic        r_state_dbg
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [7:0] OFF_TX     = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_EXIT   = 8'h10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic              wr_tx_q, wr_tx_d;
  logic              wr_exit_q, wr_exit_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exit_valid_q, exit_valid_d;
  logic              exit_done_q, exit_done_d;
  logic [31:0]       exit_code_q, exit_code_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  // Holds the address channels closed for the first cycle out of reset so
  // every ready output reads 0 while rst_b is asserted.
  logic              ready_en_q;

  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic        push, pop, exit_hit, strb_any;
  logic [7:0]  push_data;
  logic        fifo_empty, fifo_full;
  logic        aw_hit, ar_hit;
  logic [31:0] status;

  assign aw_hit     = (bus.awaddr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign ar_hit     = (bus.araddr[ADDR_W-1:8] == BASE_ADDR[ADDR_W-1:8]);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop        = char_valid && char_ready;

  // Lowest set strobe selects the byte lane; scanning downward lets the
  // lowest lane win.
  always_comb begin
    push_data = 8'h00;
    strb_any  = 1'b0;
    for (int k = STRB_W - 1; k >= 0; k--) begin
      if (bus.wstrb[k]) begin
        push_data = bus.wdata[k*8 +: 8];
        strb_any  = 1'b1;
      end
    end
  end

  always_comb begin
    status              = '0;
    status[0]           = fifo_empty;
    status[1]           = fifo_full;
    status[8 +: CNT_W]  = count_q;
    status[16]          = exit_done_q;
  end

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    wr_tx_d   = wr_tx_q;
    wr_exit_d = wr_exit_q;
    err_d     = err_q;
    bid_d     = bid_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    push      = 1'b0;
    exit_hit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = ready_en_q;
        if (bus.awvalid && ready_en_q) begin
          wr_tx_d   = aw_hit && (bus.awaddr[7:0] == OFF_TX);
          wr_exit_d = aw_hit && (bus.awaddr[7:0] == OFF_EXIT);
          err_d     = (bus.awlen != 4'd0);
          bid_d     = bus.awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Stall rather than drop a character when the FIFO is full.
        w_ready = !(wr_tx_q && !err_q && fifo_full);
        if (bus.wvalid && w_ready) begin
          push     = wr_tx_q && !err_q && strb_any;
          exit_hit = wr_exit_q && !err_q;
          if (bus.wlast) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (bus.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM; STATUS is snapshotted at the AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = ready_en_q;
        if (bus.arvalid && ready_en_q) begin
          rid_d     = bus.arid;
          rresp_d   = (bus.arlen != 4'd0) ? 2'b10 : 2'b00;
          rdata_d   = (ar_hit && bus.araddr[7:0] == OFF_STATUS) ? status : 32'h0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (bus.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // FIFO bookkeeping and exit capture
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    exit_valid_d = exit_hit;
    exit_done_d  = exit_done_q || exit_hit;
    exit_code_d  = (exit_hit && !exit_done_q) ? bus.wdata[31:0] : exit_code_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_tx_q      <= 1'b0;
      wr_exit_q    <= 1'b0;
      err_q        <= 1'b0;
      bid_q        <= '0;
      rid_q        <= '0;
      rresp_q      <= 2'b00;
      rdata_q      <= 32'h0;
      exit_valid_q <= 1'b0;
      exit_done_q  <= 1'b0;
      exit_code_q  <= 32'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_tx_q      <= wr_tx_d;
      wr_exit_q    <= wr_exit_d;
      err_q        <= err_d;
      bid_q        <= bid_d;
      rid_q        <= rid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
      exit_valid_q <= exit_valid_d;
      exit_done_q  <= exit_done_d;
      exit_code_q  <= exit_code_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign bus.awready = aw_ready;
  assign bus.wready  = w_ready;
  assign bus.bvalid  = b_valid;
  assign bus.bid     = bid_q;
  assign bus.bresp   = {err_q, 1'b0};
  assign bus.arready = ar_ready;
  assign bus.rvalid  = r_valid;
  assign bus.rlast   = r_valid;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = DATA_W'(rdata_q);

  assign char_valid  = !fifo_empty;
  assign char_data   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign exit_valid  = exit_valid_q;
  assign exit_done   = exit_done_q;
  assign exit_code   = exit_code_q;
  assign w_state_dbg = w_state_q;
  assign r_state_dbg = r_state_q;
endmodule

// File: tb/tb_axi_sim_console_slave.sv
// Bench for axi_sim_console_slave: table-driven TX and read vectors plus
// hand-written sequences for exit, burst, overlap, backpressure and reset.
module tb_axi_sim_console_slave;
  localparam int TMO = 200;
  localparam logic [39:0] A_TX     = 40'h0090000000;
  localparam logic [39:0] A_STATUS = 40'h0090000008;
  localparam logic [39:0] A_EXIT   = 40'h0090000010;

  logic        clk;
  logic        rst_b;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_data;
  logic        exit_valid;
  logic        exit_done;
  logic [31:0] exit_code;
  logic [1:0]  w_state_dbg;
  logic        r_state_dbg;

  axi_sim_console_if #(.ADDR_W(40), .DATA_W(128), .ID_W(8)) bus ();

  axi_sim_console_slave dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .bus        (bus),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_data  (char_data),
    .exit_valid (exit_valid),
    .exit_done  (exit_done),
    .exit_code  (exit_code),
    .w_state_dbg(w_state_dbg),
    .r_state_dbg(r_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int rx_cnt = 0;
  int exit_pulses = 0;
  logic [7:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_b) begin
      if (char_valid && char_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL char_unexpected: got 0x%0h expected none", char_data);
        end else begin
          check("char_data", char_data, exp_q.pop_front());
        end
      end
      if (exit_valid) exit_pulses++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input logic [39:0] addr, input logic [7:0] id, input logic [3:0] len);
    int n = 0;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awlen = len;
    @(negedge clk);
    while (!bus.awready && n < TMO) begin n++; @(negedge clk); end
    check("aw_handshake", bus.awready, 1'b1);
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [127:0] data, input logic [15:0] strb, input logic last);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    @(negedge clk);
    while (!bus.wready && n < TMO) begin n++; @(negedge clk); end
    check("w_handshake", bus.wready, 1'b1);
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic do_b(output logic [1:0] resp, output logic [7:0] id);
    int n = 0;
    bus.bready = 1'b1;
    @(negedge clk);
    while (!bus.bvalid && n < TMO) begin n++; @(negedge clk); end
    check("b_handshake", bus.bvalid, 1'b1);
    resp = bus.bresp; id = bus.bid;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_ar(input logic [39:0] addr, input logic [7:0] id, input logic [3:0] len);
    int n = 0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arlen = len;
    @(negedge clk);
    while (!bus.arready && n < TMO) begin n++; @(negedge clk); end
    check("ar_handshake", bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic do_r(output logic [127:0] data, output logic [1:0] resp,
                      output logic last, output logic [7:0] id);
    int n = 0;
    bus.rready = 1'b1;
    @(negedge clk);
    while (!bus.rvalid && n < TMO) begin n++; @(negedge clk); end
    check("r_handshake", bus.rvalid, 1'b1);
    data = bus.rdata; resp = bus.rresp; last = bus.rlast; id = bus.rid;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic write_single(input logic [39:0] addr, input logic [7:0] id, input logic [127:0] data,
                              input logic [15:0] strb, output logic [1:0] resp, output logic [7:0] bid);
    do_aw(addr, id, 4'd0);
    do_w(data, strb, 1'b1);
    do_b(resp, bid);
  endtask

  task automatic read_status(input logic [39:0] addr, input logic [7:0] id, input string name,
                             input logic [127:0] exp_data);
    logic [127:0] d; logic [1:0] r; logic l; logic [7:0] i;
    do_ar(addr, id, 4'd0);
    do_r(d, r, l, i);
    check(name, d, exp_data);
    check("status_rresp", r, 2'b00);
    check("status_rid", i, id);
  endtask

  // Filler byte k is 0xA0+k; the target lane gets the test character.
  function automatic logic [127:0] mk_data(input int lane, input logic [7:0] ch);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'hA0 + 8'(k);
    d[lane*8 +: 8] = ch;
    return d;
  endfunction

  typedef struct {
    logic [39:0] addr;
    logic [15:0] strb;
    int          lane;
    logic [7:0]  ch;
    logic        push;
  } tx_vec_t;

  typedef struct {
    logic [39:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
    logic [1:0]   resp;
    logic         chk_data;
  } rd_vec_t;

  tx_vec_t tx_tab[9];
  rd_vec_t rd_tab[5];

  logic [1:0]   resp, bg_resp;
  logic [7:0]   bid, bg_bid, rid;
  logic [127:0] rdat;
  logic         rlast;
  logic         bg_done;
  int           n, rx_before;

  initial begin
    tx_tab[0] = '{A_TX,             16'h00F0, 4,  8'h41, 1'b1};
    tx_tab[1] = '{A_TX,             16'h0001, 0,  8'h42, 1'b1};
    tx_tab[2] = '{A_TX,             16'h8000, 15, 8'h43, 1'b1};
    tx_tab[3] = '{A_TX,             16'hFFFF, 0,  8'h44, 1'b1};
    tx_tab[4] = '{A_TX,             16'h0300, 8,  8'h45, 1'b1};
    tx_tab[5] = '{A_TX,             16'h0000, 0,  8'h46, 1'b0};
    tx_tab[6] = '{40'h0091000000,   16'h0001, 0,  8'h47, 1'b0};
    tx_tab[7] = '{40'h0090000020,   16'h0001, 0,  8'h48, 1'b0};
    tx_tab[8] = '{A_STATUS,         16'h0001, 0,  8'h49, 1'b0};

    // Read table runs with the FIFO empty and no exit yet: STATUS = 0x1.
    rd_tab[0] = '{A_STATUS,       4'd0, 128'h1, 2'b00, 1'b1};
    rd_tab[1] = '{A_TX,           4'd0, 128'h0, 2'b00, 1'b1};
    rd_tab[2] = '{A_EXIT,         4'd0, 128'h0, 2'b00, 1'b1};
    rd_tab[3] = '{40'h0091000008, 4'd0, 128'h0, 2'b00, 1'b1};
    rd_tab[4] = '{A_STATUS,       4'd2, 128'h0, 2'b10, 1'b0};

    rst_b = 1'b0; char_ready = 1'b0; bg_done = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.rready = 1'b0;

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 128'h0);
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_char_data", char_data, 8'h00);
    check("rst_exit", {exit_valid, exit_done, exit_code}, 34'h0);
    tick();
    rst_b = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_awready", bus.awready, 1'b1);
    check("post_rst_w_state", w_state_dbg, 2'd0);
    check("post_rst_r_state", r_state_dbg, 1'b0);
    tick();
    char_ready = 1'b1;

    // ---- TX table ----
    for (int i = 0; i < 9; i++) begin
      if (tx_tab[i].push) exp_q.push_back(tx_tab[i].ch);
      do_aw(tx_tab[i].addr, 8'h10 + 8'(i), 4'd0);
      do_w(mk_data(tx_tab[i].lane, tx_tab[i].ch), tx_tab[i].strb, 1'b1);
      @(negedge clk);
      check("tx_char_valid", char_valid, tx_tab[i].push);
      tick();
      do_b(resp, bid);
      check("tx_bresp", resp, 2'b00);
      check("tx_bid", bid, 8'h10 + 8'(i));
    end
    repeat (4) tick();
    check("tx_table_drained", exp_q.size(), 0);
    check("tx_table_rx_cnt", rx_cnt, 5);

    // ---- read table ----
    for (int i = 0; i < 5; i++) begin
      do_ar(rd_tab[i].addr, 8'h20 + 8'(i), rd_tab[i].len);
      do_r(rdat, resp, rlast, rid);
      if (rd_tab[i].chk_data) check("rd_data", rdat, rd_tab[i].data);
      check("rd_rresp", resp, rd_tab[i].resp);
      check("rd_rlast", rlast, 1'b1);
      check("rd_rid", rid, 8'h20 + 8'(i));
    end

    // ---- EXIT: first code sticks, every store pulses ----
    write_single(A_EXIT, 8'h31, 128'h4_4433_3222, 16'hFFFF, resp, bid);
    check("exit1_bresp", resp, 2'b00);
    check("exit1_done", exit_done, 1'b1);
    check("exit1_code", exit_code, 32'h44333222);
    write_single(A_EXIT, 8'h32, 128'h1, 16'hFFFF, resp, bid);
    repeat (2) tick();
    check("exit_pulses", exit_pulses, 2);
    check("exit2_done", exit_done, 1'b1);
    check("exit2_code", exit_code, 32'h44333222);
    read_status(A_STATUS, 8'h33, "status_after_exit", 128'h0001_0001);

    // ---- burst write: consumed, no chars, SLVERR ----
    rx_before = rx_cnt;
    do_aw(A_TX, 8'h55, 4'd3);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        @(negedge clk);
        check("burst_no_early_b", bus.bvalid, 1'b0);
        tick();
      end
      do_w(mk_data(0, 8'h7A), 16'h0001, b == 3);
    end
    do_b(resp, bid);
    check("burst_bresp", resp, 2'b10);
    check("burst_bid", bid, 8'h55);
    repeat (3) tick();
    check("burst_no_chars", rx_cnt, rx_before);

    // ---- AR and AW in the same cycle, B held off ----
    exp_q.push_back(8'h72);
    bus.awvalid = 1'b1; bus.awaddr = A_TX; bus.awid = 8'h66; bus.awlen = 4'd0;
    bus.arvalid = 1'b1; bus.araddr = A_STATUS; bus.arid = 8'h77; bus.arlen = 4'd0;
    @(negedge clk);
    check("same_cycle_awready", bus.awready, 1'b1);
    check("same_cycle_arready", bus.arready, 1'b1);
    tick();
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    do_w(mk_data(0, 8'h72), 16'h0001, 1'b1);
    do_r(rdat, resp, rlast, rid);
    check("overlap_status", rdat, 128'h0001_0001);
    check("overlap_rid", rid, 8'h77);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("b_held", {bus.bvalid, bus.bresp, bus.bid}, {1'b1, 2'b00, 8'h66});
      tick();
    end
    do_b(resp, bid);
    check("overlap_bid", bid, 8'h66);

    // ---- fill to full, 17th write stalls, then drain in order ----
    repeat (3) tick();
    char_ready = 1'b0;
    rx_before = rx_cnt;
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h61 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      write_single(A_TX, 8'h40, mk_data(0, 8'h61 + 8'(i)), 16'h0001, resp, bid);
      check("fill_bresp", resp, 2'b00);
    end
    fork
      begin
        write_single(A_TX, 8'h41, mk_data(0, 8'h71), 16'h0001, bg_resp, bg_bid);
        bg_done = 1'b1;
      end
    join_none
    repeat (6) tick();
    @(negedge clk);
    check("full_wready", bus.wready, 1'b0);
    check("full_w_state", w_state_dbg, 2'd1);
    check("full_head", char_data, 8'h61);
    tick();
    read_status(A_STATUS, 8'h42, "status_full", 128'h0001_1002);
    char_ready = 1'b1;
    n = 0;
    while (!bg_done && n < TMO) begin n++; tick(); end
    check("stalled_write_done", bg_done, 1'b1);
    check("stalled_bresp", bg_resp, 2'b00);
    check("stalled_bid", bg_bid, 8'h41);
    n = 0;
    while (exp_q.size() != 0 && n < TMO) begin n++; tick(); end
    check("drain_empty", exp_q.size(), 0);
    check("drain_count", rx_cnt - rx_before, 17);

    // ---- reset in W_DATA with 3 chars queued ----
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_single(A_TX, 8'h50, mk_data(0, 8'h58), 16'h0001, resp, bid);
    do_aw(A_TX, 8'h99, 4'd0);
    @(negedge clk);
    check("pre_rst_w_state", w_state_dbg, 2'd1);
    check("pre_rst_char_valid", char_valid, 1'b1);
    tick();
    rst_b = 1'b0;
    @(negedge clk);
    check("in_rst_awready", bus.awready, 1'b0);
    check("in_rst_char_valid", char_valid, 1'b0);
    tick();
    rst_b = 1'b1;
    tick();
    @(negedge clk);
    check("after_rst_char_valid", char_valid, 1'b0);
    check("after_rst_awready", bus.awready, 1'b1);
    check("after_rst_bvalid", bus.bvalid, 1'b0);
    check("after_rst_exit_done", exit_done, 1'b0);
    check("after_rst_exit_code", exit_code, 32'h0);
    check("after_rst_w_state", w_state_dbg, 2'd0);
    tick();
    read_status(A_STATUS, 8'h60, "status_after_rst", 128'h1);

    // ---- traffic resumes after reset ----
    char_ready = 1'b1;
    exp_q.push_back(8'h5A);
    write_single(A_TX, 8'h61, mk_data(3, 8'h5A), 16'h0008, resp, bid);
    check("resume_bresp", resp, 2'b00);
    n = 0;
    while (exp_q.size() != 0 && n < TMO) begin n++; tick(); end
    check("resume_drained", exp_q.size(), 0);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
